// File: rtl/stage_renderer_pkg.sv
// Shared constants, FSM encoding and sprite art for the stage renderer.
// Sprite art lives here so the ROM and any tooling agree on one definition.
package stage_renderer_pkg;

  localparam int DEF_ORIGIN_X = 72;
  localparam int DEF_ORIGIN_Y = 32;
  localparam int TILE_PX      = 16;
  localparam int GRID_N       = 11;
  localparam int NUM_BOMBS    = 6;

  localparam logic [3:0] TILE_FLOOR    = 4'd0;
  localparam logic [3:0] TILE_WALL     = 4'd1;
  localparam logic [3:0] TILE_SOFT     = 4'd2;
  localparam logic [3:0] SPR_BOMB      = 4'd14;
  localparam logic [3:0] SPR_EXPLOSION = 4'd15;
  localparam logic [7:0] GRID_COLOUR   = 8'd7;

  localparam logic [3:0] PIX_LAST  = 4'(TILE_PX - 1);
  localparam logic [3:0] GRID_LAST = 4'(GRID_N - 1);
  localparam logic [2:0] SLOT_LAST = 3'(NUM_BOMBS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T_ADDR,
    S_T_LATCH,
    S_T_DRAW,
    S_B_ADDR,
    S_B_LATCH,
    S_B_DRAW,
    S_FLUSH
  } state_e;

  typedef struct packed {
    logic [7:0] by;
    logic [8:0] bx;
    logic       en;
  } bomb_info_t;

  // Bomb sprite has a transparent (colour 0) border so it overlays cleanly.
  function automatic logic [7:0] sprite_colour(input logic [3:0] sel,
                                               input logic [3:0] py,
                                               input logic [3:0] px);
    logic [7:0] c;
    if (sel == SPR_BOMB) begin
      if (px >= 4'd3 && px <= 4'd12 && py >= 4'd3 && py <= 4'd12)
        c = {5'd0, px[2:0] ^ py[2:0]};
      else
        c = 8'd0;
    end else if (sel == SPR_EXPLOSION) begin
      c = ({4'd0, px} * {4'd0, py}) + 8'd5;
    end else begin
      c = ({4'd0, sel} * 8'd3) + {4'd0, px} + {3'd0, py, 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/stage_renderer_sprite_rom.sv
// Sprite ROM: 16 sprites of 16x16 pixels addressed {sel, py, px}.
// Read data is registered, giving one cycle of latency.
module stage_renderer_sprite_rom
  import stage_renderer_pkg::*;
#(
  parameter int COLOUR_W = 3
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [11:0]         addr_i,
  output logic [COLOUR_W-1:0] colour_o
);

  logic [COLOUR_W-1:0] colour_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      colour_q <= '0;
    end else begin
      colour_q <= COLOUR_W'(sprite_colour(addr_i[11:8], addr_i[7:4], addr_i[3:0]));
    end
  end

  assign colour_o = colour_q;

endmodule

// File: rtl/stage_renderer.sv
// Frame renderer: sweeps the 11x11 arena tile by tile, then overlays bomb slots.
// Optional RENDER_GRID_LINES_EN forces the top/left edge of each tile to GRID_COLOUR.
module stage_renderer
  import stage_renderer_pkg::*;
#(
  parameter int COLOUR_W = 3,
  parameter int ORIGIN_X = DEF_ORIGIN_X,
  parameter int ORIGIN_Y = DEF_ORIGIN_Y
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [8:0]          X,
  output logic [7:0]          Y,
  input  logic [3:0]          map_tile_id,
  input  logic                has_explosion,
  output logic [2:0]          bomb_id,
  input  logic [17:0]         bomb_info,
  output logic                plot,
  output logic [8:0]          x,
  output logic [7:0]          y,
  output logic [COLOUR_W-1:0] colour
);

  state_e     state_q, state_d;
  logic [3:0] tx_q, tx_d, ty_q, ty_d;
  logic [3:0] px_q, px_d, py_q, py_d;
  logic [3:0] sel_q, sel_d;
  logic [2:0] slot_q, slot_d;
  logic [8:0] bx_q, bx_d;
  logic [7:0] by_q, by_d;
  logic [8:0] qx_q, qx_d;
  logic [7:0] qy_q, qy_d;
  logic [2:0] bomb_id_q, bomb_id_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic       plot_q, plot_d, bomb_pix_q, bomb_pix_d;
  logic [8:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [3:0] rom_sel;
  logic       pix_last;
  logic [COLOUR_W-1:0] rom_colour;
  bomb_info_t bi;
`ifdef RENDER_GRID_LINES_EN
  logic       grid_q, grid_d;
`endif

  assign bi       = bomb_info_t'(bomb_info);
  assign pix_last = (px_q == PIX_LAST) && (py_q == PIX_LAST);

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    ty_d       = ty_q;
    px_d       = px_q;
    py_d       = py_q;
    sel_d      = sel_q;
    slot_d     = slot_q;
    bx_d       = bx_q;
    by_d       = by_q;
    qx_d       = qx_q;
    qy_d       = qy_q;
    bomb_id_d  = bomb_id_q;
    done_d     = 1'b0;
    plot_d     = 1'b0;
    bomb_pix_d = 1'b0;
    x_d        = x_q;
    y_d        = y_q;
    rom_sel    = sel_q;
`ifdef RENDER_GRID_LINES_EN
    grid_d     = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_T_ADDR;
          tx_d    = 4'd0;
          ty_d    = 4'd0;
        end
      end
      S_T_ADDR: begin
        qx_d    = 9'(ORIGIN_X) + {1'b0, tx_q, 4'b0000};
        qy_d    = 8'(ORIGIN_Y) + {ty_q, 4'b0000};
        state_d = S_T_LATCH;
      end
      S_T_LATCH: begin
        // Map ids that collide with the overlay sprites are drawn as floor.
        if (has_explosion)
          sel_d = SPR_EXPLOSION;
        else if (map_tile_id >= SPR_BOMB)
          sel_d = TILE_FLOOR;
        else
          sel_d = map_tile_id;
        px_d    = 4'd0;
        py_d    = 4'd0;
        state_d = S_T_DRAW;
      end
      S_T_DRAW: begin
        plot_d = 1'b1;
        x_d    = qx_q + {5'd0, px_q};
        y_d    = qy_q + {4'd0, py_q};
`ifdef RENDER_GRID_LINES_EN
        grid_d = (px_q == 4'd0) || (py_q == 4'd0);
`endif
        px_d = px_q + 4'd1;
        if (px_q == PIX_LAST) py_d = py_q + 4'd1;
        if (pix_last) begin
          state_d = S_T_ADDR;
          if (tx_q == GRID_LAST) begin
            tx_d = 4'd0;
            if (ty_q == GRID_LAST) begin
              state_d = S_B_ADDR;
              slot_d  = 3'd0;
            end else begin
              ty_d = ty_q + 4'd1;
            end
          end else begin
            tx_d = tx_q + 4'd1;
          end
        end
      end
      S_B_ADDR: begin
        bomb_id_d = slot_q;
        state_d   = S_B_LATCH;
      end
      S_B_LATCH: begin
        bx_d = bi.bx;
        by_d = bi.by;
        px_d = 4'd0;
        py_d = 4'd0;
        if (bi.en) begin
          state_d = S_B_DRAW;
        end else if (slot_q == SLOT_LAST) begin
          state_d = S_FLUSH;
        end else begin
          slot_d  = slot_q + 3'd1;
          state_d = S_B_ADDR;
        end
      end
      S_B_DRAW: begin
        plot_d     = 1'b1;
        bomb_pix_d = 1'b1;
        rom_sel    = SPR_BOMB;
        x_d        = bx_q + {5'd0, px_q};
        y_d        = by_q + {4'd0, py_q};
        px_d = px_q + 4'd1;
        if (px_q == PIX_LAST) py_d = py_q + 4'd1;
        if (pix_last) begin
          if (slot_q == SLOT_LAST) begin
            state_d = S_FLUSH;
          end else begin
            slot_d  = slot_q + 3'd1;
            state_d = S_B_ADDR;
          end
        end
      end
      S_FLUSH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tx_q       <= '0;
      ty_q       <= '0;
      px_q       <= '0;
      py_q       <= '0;
      sel_q      <= '0;
      slot_q     <= '0;
      bx_q       <= '0;
      by_q       <= '0;
      qx_q       <= 9'(ORIGIN_X);
      qy_q       <= 8'(ORIGIN_Y);
      bomb_id_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      plot_q     <= 1'b0;
      bomb_pix_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
`ifdef RENDER_GRID_LINES_EN
      grid_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      ty_q       <= ty_d;
      px_q       <= px_d;
      py_q       <= py_d;
      sel_q      <= sel_d;
      slot_q     <= slot_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      qx_q       <= qx_d;
      qy_q       <= qy_d;
      bomb_id_q  <= bomb_id_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      plot_q     <= plot_d;
      bomb_pix_q <= bomb_pix_d;
      x_q        <= x_d;
      y_q        <= y_d;
`ifdef RENDER_GRID_LINES_EN
      grid_q     <= grid_d;
`endif
    end
  end

  stage_renderer_sprite_rom #(
    .COLOUR_W (COLOUR_W)
  ) u_sprite_rom (
    .clk_i    (clk),
    .reset_i  (reset),
    .addr_i   ({rom_sel, py_q, px_q}),
    .colour_o (rom_colour)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign X       = qx_q;
  assign Y       = qy_q;
  assign bomb_id = bomb_id_q;
  assign x       = x_q;
  assign y       = y_q;
  // ROM data arrives alongside the registered strobe; transparency is resolved here.
  assign plot    = plot_q & ~(bomb_pix_q & (rom_colour == '0));
`ifdef RENDER_GRID_LINES_EN
  assign colour  = grid_q ? COLOUR_W'(GRID_COLOUR) : rom_colour;
`else
  assign colour  = rom_colour;
`endif

endmodule

// File: tb/tb_stage_renderer.sv
// Bench for stage_renderer: directed and random arenas checked against a pixel-list model.
module tb_stage_renderer;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset, start;
  logic          busy, done;
  logic [8:0]    X;
  logic [7:0]    Y;
  logic [3:0]    map_tile_id;
  logic          has_explosion;
  logic [2:0]    bomb_id;
  logic [17:0]   bomb_info;
  logic          plot;
  logic [8:0]    x;
  logic [7:0]    y;
  logic [CW-1:0] colour;

  logic [3:0]  map_id [0:10][0:10];
  logic        expl   [0:10][0:10];
  logic [17:0] binfo  [0:7];

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  typedef struct packed { int cyc; int px; int py; int c; } pix_t;
  pix_t        exp_q[$];
  int          exp_done;
  int          exp_total;
  logic [63:0] exp_last;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  stage_renderer #(.COLOUR_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .X             (X),
    .Y             (Y),
    .map_tile_id   (map_tile_id),
    .has_explosion (has_explosion),
    .bomb_id       (bomb_id),
    .bomb_info     (bomb_info),
    .plot          (plot),
    .x             (x),
    .y             (y),
    .colour        (colour)
  );

  // Bomb-block stub: tile lookup from the query pixel, slot lookup from bomb_id.
  logic [8:0] dx;
  logic [7:0] dy;
  logic [3:0] stub_tx, stub_ty;
  assign dx = X - 9'd72;
  assign dy = Y - 8'd32;
  assign stub_tx = (dx[8:4] <= 5'd10) ? dx[7:4] : 4'd0;
  assign stub_ty = (dy[7:4] <= 4'd10) ? dy[7:4] : 4'd0;
  assign map_tile_id   = map_id[stub_ty][stub_tx];
  assign has_explosion = expl[stub_ty][stub_tx];
  assign bomb_info     = binfo[bomb_id];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference sprite art, 16x16 per id.
  function automatic int spr(input int sel, input int px, input int py);
    if (sel == 14) return (px >= 3 && px <= 12 && py >= 3 && py <= 12) ? ((px % 8) ^ (py % 8)) : 0;
    if (sel == 15) return (px * py + 5) % 8;
    return (sel * 3 + px + 2 * py) % 8;
  endfunction

  function automatic logic [63:0] pk(input int cyc, input int px, input int py, input int c);
    return {32'(cyc), 7'd0, 9'(px), 8'(py), 8'(c)};
  endfunction

  // Expected plot list for one frame: cycle offset after the start-accept edge, position, colour.
  task automatic build_model();
    int t, sel, c, tx, ty, bx, by;
    exp_q.delete();
    for (int k = 0; k < 121; k++) begin
      tx = k % 11;
      ty = k / 11;
      if (expl[ty][tx]) sel = 15;
      else if (int'(map_id[ty][tx]) >= 14) sel = 0;
      else sel = int'(map_id[ty][tx]);
      for (int i = 0; i < 256; i++) begin
        c = spr(sel, i % 16, i / 16);
`ifdef RENDER_GRID_LINES_EN
        if (i % 16 == 0 || i / 16 == 0) c = 7;
`endif
        exp_q.push_back('{258 * k + 3 + i, 72 + 16 * tx + i % 16, 32 + 16 * ty + i / 16, c});
      end
    end
    t = 121 * 258;
    for (int s = 0; s < 6; s++) begin
      if (binfo[s][0]) begin
        bx = int'(binfo[s][9:1]);
        by = int'(binfo[s][17:10]);
        for (int i = 0; i < 256; i++) begin
          c = spr(14, i % 16, i / 16);
          if (c != 0) exp_q.push_back('{t + 3 + i, bx + i % 16, by + i / 16, c});
        end
        t += 258;
      end else begin
        t += 2;
      end
    end
    exp_done  = t + 1;
    exp_total = exp_q.size();
    exp_last  = {47'd0, 9'(exp_q[exp_q.size() - 1].px), 8'(exp_q[exp_q.size() - 1].py)};
  endtask

  // Starts a frame and checks every plotted pixel; abort_at > 0 resets the DUT at that offset.
  task automatic run_frame(input int abort_at);
    int   n, rel, nplot;
    bit   finished;
    pix_t e;
    logic [63:0] last_xy;
    last_xy = '0;
    @(negedge clk);
    start = 1'b1;
    n = edge_cnt + 1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_rise", 64'(busy), 64'd1);
    finished = 1'b0;
    nplot = 0;
    while (!finished) begin
      rel = edge_cnt - n;
      if (plot === 1'b1) begin
        nplot++;
        if (exp_q.size() == 0) begin
          check_eq("extra_plot", 64'(nplot), 64'(exp_total));
        end else begin
          e = exp_q.pop_front();
          check_eq("pixel", pk(rel, int'(x), int'(y), int'(colour)), pk(e.cyc, e.px, e.py, e.c));
        end
        if (nplot == 1) check_eq("first_xy", {47'd0, x, y}, {47'd0, 9'd72, 8'd32});
        last_xy = {47'd0, x, y};
      end
      if (done === 1'b1) begin
        check_eq("done_cycle", 64'(rel), 64'(exp_done));
        check_eq("busy_fall", 64'(busy), 64'd0);
        @(negedge clk);
        check_eq("done_pulse", 64'(done), 64'd0);
        finished = 1'b1;
      end else if (abort_at > 0 && rel == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_plot", 64'(plot), 64'd0);
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_X", 64'(X), 64'd72);
        reset = 1'b0;
        start = 1'b0;
        return;
      end else if (rel > exp_done + 8) begin
        check_eq("timeout", 64'(rel), 64'(exp_done));
        finished = 1'b1;
      end else begin
        start = (rel == 1000);
        @(negedge clk);
      end
    end
    start = 1'b0;
    check_eq("plot_count", 64'(nplot), 64'(exp_total));
    check_eq("last_xy", last_xy, exp_last);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b1;
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 11; c++) begin
        map_id[r][c] = 4'd0;
        expl[r][c]   = 1'b0;
      end
    for (int s = 0; s < 8; s++) binfo[s] = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_plot", 64'(plot), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_X", 64'(X), 64'd72);
    check_eq("rst_Y", 64'(Y), 64'd32);
    check_eq("rst_bomb_id", 64'(bomb_id), 64'd0);
    check_eq("rst_xy", {47'd0, x, y}, 64'd0);
    check_eq("rst_colour", 64'(colour), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("start_in_reset", 64'(busy), 64'd0);

    // Directed arena: soft block at (3,2), explosion over a wall at (5,5), bomb slot 2 at (88,48).
    map_id[2][3] = 4'd2;
    map_id[5][5] = 4'd1;
    expl[5][5]   = 1'b1;
    binfo[2]     = {8'd48, 9'd88, 1'b1};
    build_model();
    run_frame(0);

    // Random arena (ids 0..15, sparse explosions), bomb slots all disabled.
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 11; c++) begin
        map_id[r][c] = 4'($urandom_range(0, 15));
        expl[r][c]   = ($urandom_range(0, 7) == 0);
      end
    for (int s = 0; s < 8; s++) binfo[s] = '0;
    build_model();
    run_frame(5000);
    repeat (3) @(negedge clk);
    check_eq("idle_after_abort", 64'(busy), 64'd0);
    build_model();
    run_frame(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
